key_debouncer: RTL



---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce_ch.sv | 104 ++++++++++
 rtl/key_debouncer.sv | 56 +++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared constants and helpers for the push-button debouncer.
//
// Contents:
//   SYNC_STAGES   - depth of the input synchroniser (s1, s2)
//   cnt_width_t   - type used to carry counter-width values
//   deb_cycles_f  - stability window in clock cycles (clk_mhz * debounce_us)
//   cnt_width_f   - counter width able to hold 0 .. deb_cycles
package key_pkg;

  localparam int SYNC_STAGES = 2;

  typedef int unsigned cnt_width_t;

  function automatic int deb_cycles_f(input int clk_mhz, input int debounce_us);
    return clk_mhz * debounce_us;
  endfunction

  function automatic cnt_width_t cnt_width_f(input int deb_cycles);
    return cnt_width_t'($clog2(deb_cycles + 1));
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one debounced key channel.
//
// Takes an already polarity-normalised key (1 = pressed), synchronises it
// through SYNC_STAGES flops, and only accepts a new level once the
// synchronised value has disagreed with the stable level for DEB_CYCLES
// consecutive cycles. A single agreeing cycle restarts the count.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_pressed  in   raw key, 1 = pressed, not yet synchronised
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  one-cycle pulse in the first cycle key_level reads 1
//   key_release  out  one-cycle pulse in the first cycle key_level reads 0
//   key_toggle   out  flips once per press when KEY_DEBOUNCER_TOGGLE_EN is
//                     defined, otherwise constant 0
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_pressed,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int CW = int'(cnt_width_f(DEB_CYCLES));

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   st_q, st_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s2;

  assign s2 = sync_q[SYNC_STAGES-1];

  // The counter only runs while s2 disagrees with the stable level and is
  // cleared on the qualifying cycle, so it tops out at DEB_CYCLES-1.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], key_pressed};
    st_d      = st_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2 == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      st_d      = s2;
      cnt_d     = '0;
      press_d   = s2;
      release_d = ~s2;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      st_q      <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = st_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic tog_q, tog_d;

  // Flips on the edge that ends the press pulse, so the new value appears
  // one cycle after key_press.
  always_comb begin
    tog_d = tog_q ^ press_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign key_toggle = tog_q;
`else
  assign key_toggle = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: synchronise, debounce and polarity-normalise w_key
// board push-buttons, giving clean levels and press/release pulses.
//
// Optional feature macro: KEY_DEBOUNCER_TOGGLE_EN (per-key toggle state on
// key_toggle; when undefined key_toggle is tied to 0).
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_raw      in   [w_key] unsynchronised board keys
//   key_level    out  [w_key] debounced state, 1 = pressed
//   key_press    out  [w_key] one-cycle pulse on debounced press
//   key_release  out  [w_key] one-cycle pulse on debounced release
//   key_toggle   out  [w_key] per-key toggle state
module key_debouncer
  import key_pkg::*;
#(
  parameter int clk_mhz        = 50,
  parameter int w_key          = 4,
  parameter int debounce_us    = 10000,
  parameter int key_active_low = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w_key-1:0] key_raw,
  output logic [w_key-1:0] key_level,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic [w_key-1:0] key_toggle
);

  localparam int deb_cycles = deb_cycles_f(clk_mhz, debounce_us);

  if (deb_cycles < 2) begin : g_bad_deb_cycles
    $error("key_debouncer: deb_cycles must be at least 2");
  end

  logic [w_key-1:0] key_pressed;

  assign key_pressed = (key_active_low != 0) ? ~key_raw : key_raw;

  for (genvar i = 0; i < w_key; i++) begin : g_key
    key_debounce_ch #(
      .DEB_CYCLES(deb_cycles)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_pressed(key_pressed[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_toggle (key_toggle[i])
    );
  end

endmodule
